alu_writeback_sequencer: RTL and testbench
==========================================

Name: alu_writeback_sequencer

Overview:
Multi-cycle control stage that sits directly upstream of the register file / ALU datapath and drives all of its control inputs. It accepts one register-register instruction at a time over a valid/ready handshake and sequences it: read rs1/rs2, drive the ALU, write the result back to rd. It also reports completion and keeps a retired-instruction count.

Parameters:
- DATA_W, 32, data width of register, ALU and result paths.
- ADDR_W, 5, register address width.
- ZERO_REG_RO, 1, when 1 a write-back to register 0 is suppressed (rf_we3 stays low); done still pulses.
- CNT_W, 16, width of retired_count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  an instruction is offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_op  in  2  ALU opcode, passed through unchanged.
- instr_rs1  in  ADDR_W  source register A.
- instr_rs2  in  ADDR_W  source register B.
- instr_rd  in  ADDR_W  destination register.
- rf_a1  out  ADDR_W  register file read address 1.
- rf_a2  out  ADDR_W  register file read address 2.
- rf_rd1  in  DATA_W  read data 1; combinational from rf_a1.
- rf_rd2  in  DATA_W  read data 2; combinational from rf_a2.
- rf_we3  out  1  register file write enable.
- rf_a3  out  ADDR_W  write address.
- rf_wd3  out  DATA_W  write data.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- alu_op  out  2  ALU opcode.
- alu_result  in  DATA_W  ALU result; combinational.
- done  out  1  one-cycle pulse, asserted in the write-back cycle.
- done_rd  out  ADDR_W  destination of the completed instruction; valid while done=1.
- done_value  out  DATA_W  result written; valid while done=1.
- retired_count  out  CNT_W  number of completed instructions.

Behaviour:
- FSM states: IDLE, READ, EXEC, WB. Reset forces IDLE.
- IDLE: instr_ready = 1 (0 while rst = 1). On instr_valid && instr_ready:
  - latch op, rs1, rs2 and rd into internal registers;
  - go to READ.
  - Otherwise stay in IDLE; inputs are ignored.
- READ: rf_a1/rf_a2 = latched rs1/rs2. Capture rf_rd1/rf_rd2 into operand registers opA/opB at the clock edge, then go to EXEC.
- EXEC: alu_a = opA, alu_b = opB, alu_op = latched op. Capture alu_result into the result register at the edge, then go to WB.
- WB:
  - rf_a3 = latched rd, rf_wd3 = result register;
  - rf_we3 = 1, except 0 when ZERO_REG_RO = 1 and rd = 0;
  - done = 1, done_rd = rd, done_value = result register;
  - retired_count increments at the edge, wrapping from 2^CNT_W-1 to 0;
  - next state IDLE.
- instr_ready is low in READ, EXEC and WB. Throughput is one instruction per 4 cycles.
- Latency: handshake accepted at edge N; rf_we3 and done are high during cycle N+3; the register is updated at the end of cycle N+3.
- A new instruction accepted in the IDLE cycle after WB reads the updated register file. No forwarding is required; RAW hazards are resolved by serialisation.
- All outputs are registered or decoded only from state and internal registers. There is no combinational path from instr_* to any output except instr_ready, which depends only on state and rst.
- rf_a1/rf_a2/alu_a/alu_b/alu_op hold their last values outside their active states. rf_a3/rf_wd3 hold their last values; only rf_we3 qualifies a write.
- Same source registers (rs1 = rs2) are legal. rd equal to rs1 or rs2 is legal; operands are captured before the write.
- Reset values: state IDLE; every latched field, opA, opB, result, rf_a1/a2/a3, rf_wd3, alu_a/b, alu_op, done_rd, done_value and retired_count = 0; rf_we3 = 0; done = 0; instr_ready = 0 while rst is high, 1 in the first cycle after release.
- Reset mid-operation (READ/EXEC/WB): abort immediately. No write occurs in the reset cycle (rf_we3 = 0), done = 0, and retired_count is cleared.
- instr_valid dropping while in IDLE is legal; no state change occurs.

Test Plan:
- Reset release: after rst high for 2 cycles and low, instr_ready=1, rf_we3=0, done=0, retired_count=0; all address and data outputs are 0.
- Add: preload r1=5, r2=7 (ALU 00=add). Offer op=00, rs1=1, rs2=2, rd=3 at cycle N -> rf_we3=1, rf_a3=3, rf_wd3=12 and done=1 only in cycle N+3; r3 then reads 12; retired_count=1.
- Back-to-back with rd as a source: (op=01 sub, rs1=3, rs2=1, rd=3) held valid continuously. instr_ready stays low for 3 cycles, then the next instruction uses the updated r3. First write is 7; the second (if repeated) writes 2.
- Zero register: op=00, rs1=1, rs2=2, rd=0 with ZERO_REG_RO=1 -> rf_we3 stays 0, done=1, done_rd=0, done_value=12, retired_count increments.
- Reset in EXEC: accept an instruction, assert rst in cycle N+2 -> no rf_we3 or done pulse ever appears for it; state IDLE; retired_count=0.
- Counter wrap: with CNT_W=4, retire 17 instructions -> retired_count=1; the sequence ..., 15, 0, 1 is observed.

Source files
------------

// File: rtl/alu_writeback_sequencer.sv
// Four-state control sequencer (IDLE -> READ -> EXEC -> WB) that runs one
// register-register instruction at a time through an external register file and ALU.
module alu_writeback_sequencer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int ZERO_REG_RO = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [ADDR_W-1:0] instr_rd,
  output logic [ADDR_W-1:0] rf_a1,
  output logic [ADDR_W-1:0] rf_a2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              rf_we3,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic [ADDR_W-1:0] done_rd,
  output logic [DATA_W-1:0] done_value,
  output logic [CNT_W-1:0]  retired_count
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] a1_q, a1_d;
  logic [ADDR_W-1:0] a2_q, a2_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;

  function automatic logic wb_enable(input logic [ADDR_W-1:0] rd);
    return !((ZERO_REG_RO != 0) && (rd == '0));
  endfunction

  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    a1_d     = a1_q;
    a2_d     = a2_q;
    a3_d     = a3_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    alu_op_d = alu_op_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Read addresses are loaded here so they are already stable for the READ cycle.
          op_d    = instr_op;
          rd_d    = instr_rd;
          a1_d    = instr_rs1;
          a2_d    = instr_rs2;
          state_d = S_READ;
        end
      end
      S_READ: begin
        opa_d    = rf_rd1;
        opb_d    = rf_rd2;
        alu_op_d = op_q;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_result;
        a3_d    = rd_q;
        we_d    = wb_enable(rd_q);
        done_d  = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      a1_q     <= '0;
      a2_q     <= '0;
      a3_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      alu_op_q <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      a3_q     <= a3_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      alu_op_q <= alu_op_d;
      we_q     <= we_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  // Reset asserted during WB must suppress the write and the completion pulse in that same cycle.
  assign rf_we3        = we_q && !rst;
  assign done          = done_q && !rst;
  assign rf_a1         = a1_q;
  assign rf_a2         = a2_q;
  assign rf_a3         = a3_q;
  assign rf_wd3        = res_q;
  assign alu_a         = opa_q;
  assign alu_b         = opb_q;
  assign alu_op        = alu_op_q;
  assign done_rd       = a3_q;
  assign done_value    = res_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_alu_writeback_sequencer.sv
// Bench for alu_writeback_sequencer: register-file/ALU environment, an
// instruction-level reference model checked every cycle, and directed scenarios.
module tb_alu_writeback_sequencer;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [1:0]    instr_op = '0;
  logic [AW-1:0] instr_rs1 = '0, instr_rs2 = '0, instr_rd = '0;
  logic [AW-1:0] rf_a1, rf_a2, rf_a3, done_rd;
  logic [DW-1:0] rf_rd1, rf_rd2, rf_wd3, alu_a, alu_b, alu_result, done_value;
  logic          rf_we3, done;
  logic [1:0]    alu_op;
  logic [CW-1:0] retired_count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_writeback_sequencer #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG_RO(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_we3(rf_we3), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .done(done), .done_rd(done_rd), .done_value(done_value), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // Environment: register file and ALU the sequencer controls.
  logic [DW-1:0] rf_mem [32];
  assign rf_rd1     = rf_mem[rf_a1];
  assign rf_rd2     = rf_mem[rf_a2];
  assign alu_result = alu_f(alu_op, alu_a, alu_b);
  always @(posedge clk) if (rf_we3) rf_mem[rf_a3] <= rf_wd3;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus at most one in-flight instruction.
  typedef struct {
    int            due;
    logic [1:0]    op;
    logic [AW-1:0] rs1, rs2, rd;
    logic [DW-1:0] a, b, val;
  } pend_t;

  logic [DW-1:0] arch [32];
  pend_t p;
  bit    p_v = 0;
  int    c = 0;
  int    mcnt = 0;
  bit    cnt_known = 0;

  always @(negedge clk) begin : cmp
    bit exp_ready, wb;
    c++;
    exp_ready = !rst && !p_v;
    wb        = p_v && (p.due == c);
    chk("instr_ready", DW'(instr_ready), DW'(exp_ready));
    chk("done", DW'(done), DW'(wb && !rst));
    chk("rf_we3", DW'(rf_we3), DW'(wb && !rst && p.rd != 0));
    if (wb && !rst) begin
      chk("rf_a3", DW'(rf_a3), DW'(p.rd));
      chk("rf_wd3", rf_wd3, p.val);
      chk("done_rd", DW'(done_rd), DW'(p.rd));
      chk("done_value", done_value, p.val);
    end
    if (p_v && p.due == c + 2) begin
      chk("rf_a1", DW'(rf_a1), DW'(p.rs1));
      chk("rf_a2", DW'(rf_a2), DW'(p.rs2));
    end
    if (p_v && p.due == c + 1) begin
      chk("alu_a", alu_a, p.a);
      chk("alu_b", alu_b, p.b);
      chk("alu_op", DW'(alu_op), DW'(p.op));
    end
    if (!rst && cnt_known) chk("retired_count", DW'(retired_count), DW'(mcnt));
    if (rst) begin
      p_v = 0; mcnt = 0; cnt_known = 1;
    end else begin
      if (wb) begin
        if (p.rd != 0) arch[p.rd] = p.val;
        mcnt = (mcnt + 1) % (1 << CW);
        p_v  = 0;
      end
      if (exp_ready && instr_valid) begin
        p_v   = 1;
        p.due = c + 3;
        p.op  = instr_op; p.rs1 = instr_rs1; p.rs2 = instr_rs2; p.rd = instr_rd;
        p.a   = arch[instr_rs1];
        p.b   = arch[instr_rs2];
        p.val = alu_f(instr_op, p.a, p.b);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input int rs1, input int rs2, input int rd);
    bit acc = 0;
    instr_valid = 1'b1; instr_op = op;
    instr_rs1 = AW'(rs1); instr_rs2 = AW'(rs2); instr_rd = AW'(rd);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_ready) begin acc = 1; break; end
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no handshake expected handshake within 20 cycles");
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [DW-1:0] val, input int rd, input bit we);
    bit seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk({name, "_seen"}, DW'(seen), DW'(1));
    if (seen) begin
      chk({name, "_value"}, done_value, val);
      chk({name, "_rd"}, DW'(done_rd), DW'(rd));
      chk({name, "_we"}, DW'(rf_we3), DW'(we));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [DW-1:0] vals [$];
    int acc;
    for (int i = 0; i < 32; i++) begin rf_mem[i] = '0; arch[i] = '0; end
    rf_mem[1] = 32'd5;          arch[1] = 32'd5;
    rf_mem[2] = 32'd7;          arch[2] = 32'd7;
    rf_mem[4] = 32'hF0F0_0003;  arch[4] = 32'hF0F0_0003;
    rf_mem[5] = 32'h0000_FFFF;  arch[5] = 32'h0000_FFFF;
    rf_mem[6] = 32'd100;        arch[6] = 32'd100;
    rf_mem[7] = 32'h8000_0000;  arch[7] = 32'h8000_0000;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", DW'(instr_ready), DW'(1));
    chk("rst_we", DW'(rf_we3), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_count", DW'(retired_count), DW'(0));
    chk("rst_addrs", DW'({rf_a1, rf_a2, rf_a3, done_rd}), DW'(0));
    chk("rst_data", alu_a | alu_b | rf_wd3 | done_value | DW'(alu_op), DW'(0));
    @(posedge clk); #1;

    // r3 = r1 + r2
    issue(2'd0, 1, 2, 3);
    wait_done("add", 32'd12, 3, 1'b1);
    @(negedge clk);
    chk("add_r3", rf_mem[3], 32'd12);
    chk("add_count", DW'(retired_count), DW'(1));
    @(posedge clk); #1;

    // r3 = r3 - r1, offered continuously twice
    instr_valid = 1'b1; instr_op = 2'd1; instr_rs1 = 5'd3; instr_rs2 = 5'd1; instr_rd = 5'd3;
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done) vals.push_back(done_value);
      if (instr_ready && instr_valid) begin
        acc++;
        if (acc == 2) begin @(posedge clk); #1 instr_valid = 1'b0; end
      end
    end
    chk("b2b_count", DW'(vals.size()), DW'(2));
    if (vals.size() == 2) begin
      chk("b2b_first", vals[0], 32'd7);
      chk("b2b_second", vals[1], 32'd2);
    end
    @(posedge clk); #1;

    // write to r0 is suppressed
    issue(2'd0, 1, 2, 0);
    wait_done("zero", 32'd12, 0, 1'b0);
    @(negedge clk);
    chk("zero_r0", rf_mem[0], 32'd0);
    chk("zero_count", DW'(retired_count), DW'(4));
    @(posedge clk); #1;

    // reset while in EXEC
    issue(2'd2, 4, 5, 6);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_r6", rf_mem[6], 32'd100);
    chk("abort_count", DW'(retired_count), DW'(0));
    @(posedge clk); #1;

    // 17 retirements wrap the 4-bit counter
    for (int i = 0; i < 17; i++) begin
      issue(2'(i % 4), i % 8, (i + 3) % 8, 4 + (i % 4));
      @(negedge clk); @(negedge clk); @(negedge clk);
      @(negedge clk);
      if (i == 14) chk("wrap_15", DW'(retired_count), DW'(15));
      if (i == 15) chk("wrap_0", DW'(retired_count), DW'(0));
      if (i == 16) chk("wrap_1", DW'(retired_count), DW'(1));
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
